// File: rtl/brlite_svc_rx_queue_if.sv
// Service-packet type plus the router/NI bundle used by brlite_svc_rx_queue.
// master = router + NI side (the environment), slave = the queue itself.
package brlite_svc_pkg;
  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;
endpackage

interface brlite_svc_rx_queue_if;
  logic                      br_req_i;
  logic                      br_ack_o;
  brlite_svc_pkg::brlite_svc_t br_data_i;
  logic                      br_svc_rx_o;
  brlite_svc_pkg::brlite_svc_t br_svc_data_o;
  logic                      br_svc_ack_i;

  modport master (
    output br_req_i, br_data_i, br_svc_ack_i,
    input  br_ack_o, br_svc_rx_o, br_svc_data_o
  );

  modport slave (
    input  br_req_i, br_data_i, br_svc_ack_i,
    output br_ack_o, br_svc_rx_o, br_svc_data_o
  );
endinterface

// File: rtl/brlite_svc_rx_queue.sv
// Router-to-NI service packet FIFO with req/ack capture FSM and FWFT head.
// Optional BRLITE_SVC_DROP_EN: ack-and-drop when full, counting drops.
module brlite_svc_rx_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  brlite_svc_rx_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [CNT_W-1:0]          drop_cnt_o
);
  import brlite_svc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  brlite_svc_t     mem_reg [DEPTH];
  brlite_svc_t     head_reg;
  logic            svc_rx_reg;
  logic            full, empty, push, pop;
`ifdef BRLITE_SVC_DROP_EN
  logic            drop;
  logic [CNT_W-1:0] drop_cnt_reg;
`endif

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = bus.br_svc_ack_i && !empty;

  // Only IDLE can capture, so a req still held after ack is never taken twice.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
`ifdef BRLITE_SVC_DROP_EN
    drop       = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (bus.br_req_i) begin
          if (!full) begin
            push       = 1'b1;
            state_next = ACK;
          end
`ifdef BRLITE_SVC_DROP_EN
          else begin
            drop       = 1'b1;
            state_next = ACK;
          end
`endif
        end
      end
      ACK:      state_next = WAIT_LOW;
      WAIT_LOW: if (!bus.br_req_i) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign wr_ptr_next = wr_ptr_reg + PW'(push);
  assign rd_ptr_next = rd_ptr_reg + PW'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      svc_rx_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      svc_rx_reg <= (wr_ptr_next != rd_ptr_next);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= bus.br_data_i;
  end

  // Registered head read at the next read address; bypass when that slot is written now.
  always_ff @(posedge clk_i) begin
    if (push && (rd_ptr_next == wr_ptr_reg)) head_reg <= bus.br_data_i;
    else                                     head_reg <= mem_reg[rd_ptr_next[AW-1:0]];
  end

`ifdef BRLITE_SVC_DROP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                              drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != '1))  drop_cnt_reg <= drop_cnt_reg + 1'b1;
  end
  assign drop_cnt_o = drop_cnt_reg;
`else
  assign drop_cnt_o = '0;
`endif

  assign bus.br_ack_o      = (state_reg == ACK);
  assign bus.br_svc_rx_o   = svc_rx_reg;
  assign bus.br_svc_data_o = head_reg;
  assign level_o           = wr_ptr_reg - rd_ptr_reg;
endmodule

// File: tb/tb_brlite_svc_rx_queue.sv
// Scoreboard bench for brlite_svc_rx_queue: stimulus queues expected pops,
// a negedge monitor compares the head whenever the NI pops a non-empty queue.
module tb_brlite_svc_rx_queue;
  import brlite_svc_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = 3;
`ifdef BRLITE_SVC_DROP_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  brlite_svc_rx_queue_if bus();
  logic [LW-1:0] level;
  logic [CW-1:0] drop_cnt;

  brlite_svc_rx_queue #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .level_o    (level),
    .drop_cnt_o (drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  brlite_svc_t exp_q[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic brlite_svc_t mk(input logic [7:0] k, input logic [31:0] pl);
    brlite_svc_t r;
    r.ksvc       = k;
    r.seq_source = {8'h5a, k};
    r.producer   = pl[15:0] ^ 16'h0f0f;
    r.payload    = pl;
    return r;
  endfunction

  // Monitor: every pop of a non-empty queue must present the oldest expected entry.
  always @(negedge clk) begin
    brlite_svc_t e;
    if (!rst && bus.br_svc_ack_i && bus.br_svc_rx_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", bus.br_svc_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", bus.br_svc_data_o, e);
        $display("pop  ksvc=%0h payload=%0h", bus.br_svc_data_o.ksvc, bus.br_svc_data_o.payload);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pop();
    bus.br_svc_ack_i = 1'b1;
    cyc();
    bus.br_svc_ack_i = 1'b0;
  endtask

  task automatic send(input brlite_svc_t p, input bit store, input int hold_extra);
    bit acked = 1'b0;
    if (store) exp_q.push_back(p);
    bus.br_data_i = p;
    bus.br_req_i  = 1'b1;
    for (int i = 0; i < 10 && !acked; i++) begin
      cyc();
      acked = bus.br_ack_o;
    end
    chk("ack_seen", acked, 1);
    $display("push ksvc=%0h payload=%0h acked=%0d", p.ksvc, p.payload, acked);
    cyc();
    chk("ack_pulse", bus.br_ack_o, 0);
    for (int i = 0; i < hold_extra; i++) begin
      cyc();
      chk("ack_stale", bus.br_ack_o, 0);
    end
    bus.br_req_i = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acked;
    brlite_svc_t p;
    bus.br_req_i     = 1'b0;
    bus.br_data_i    = '0;
    bus.br_svc_ack_i = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_ack", bus.br_ack_o, 0);
    chk("rst_rx", bus.br_svc_rx_o, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    cyc();

    // Single packet
    send(mk(8'h12, 32'hDEADBEEF), 1'b1, 0);
    chk("single_rx", bus.br_svc_rx_o, 1);
    chk("single_level", level, 1);
    chk("single_payload", bus.br_svc_data_o.payload, 32'hDEADBEEF);
    pop();
    chk("single_rx_after_pop", bus.br_svc_rx_o, 0);
    chk("single_level_after_pop", level, 0);

    // Req held long after ack: one capture only
    send(mk(8'h21, 32'h0000_0BAD), 1'b1, 5);
    chk("held_level", level, 1);
    pop();
    chk("held_level_after_pop", level, 0);

    // Pop while empty is ignored
    pop();
    chk("empty_pop_level", level, 0);
    chk("empty_pop_rx", bus.br_svc_rx_o, 0);

    // Fill to DEPTH
    for (int k = 1; k <= DEPTH; k++) send(mk(8'(k), 32'(k)), 1'b1, 0);
    chk("full_level", level, 4);
    chk("full_rx", bus.br_svc_rx_o, 1);

`ifdef BRLITE_SVC_DROP_EN
    for (int k = 5; k <= 7; k++) send(mk(8'(k), 32'(k)), 1'b0, 0);
    chk("drop_cnt3", drop_cnt, 3);
    chk("drop_level", level, 4);
    for (int k = 8; k <= 9; k++) send(mk(8'(k), 32'(k)), 1'b0, 0);
    chk("drop_cnt_sat", drop_cnt, 3);
    chk("drop_level2", level, 4);
    repeat (4) pop();
    chk("drop_drained", level, 0);
`else
    p = mk(8'h05, 32'h5);
    exp_q.push_back(p);
    bus.br_data_i = p;
    bus.br_req_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_no_ack", bus.br_ack_o, 0);
    end
    chk("bp_level", level, 4);
    pop();
    chk("bp_blocked_on_pop", bus.br_ack_o, 0);
    cyc();
    chk("bp_ack_after_pop", bus.br_ack_o, 1);
    cyc();
    chk("bp_ack_pulse", bus.br_ack_o, 0);
    bus.br_req_i = 1'b0;
    cyc();
    chk("bp_level_refill", level, 4);
    chk("bp_drop_zero", drop_cnt, 0);
    repeat (4) pop();
    chk("bp_drained", level, 0);
`endif

    // Simultaneous push and pop at level 2
    send(mk(8'hA1, 32'hAAAA_0001), 1'b1, 0);
    send(mk(8'hA2, 32'hAAAA_0002), 1'b1, 0);
    chk("sim_level_pre", level, 2);
    p = mk(8'hA3, 32'hAAAA_0003);
    exp_q.push_back(p);
    bus.br_data_i    = p;
    bus.br_req_i     = 1'b1;
    bus.br_svc_ack_i = 1'b1;
    cyc();
    bus.br_svc_ack_i = 1'b0;
    chk("sim_ack", bus.br_ack_o, 1);
    chk("sim_level", level, 2);
    cyc();
    bus.br_req_i = 1'b0;
    cyc();
    chk("sim_level_post", level, 2);
    repeat (2) pop();
    chk("sim_drained", level, 0);

    // Pointer wrap with push/pop pairs
    for (int i = 0; i < 10; i++) begin
      send(mk(8'(8'h40 + i), 32'h1000 + 32'(i)), 1'b1, 0);
      pop();
      chk("wrap_level", level, 0);
    end

    // Reset during ACK; held req is taken again afterwards
    p = mk(8'h77, 32'h7777_7777);
    bus.br_data_i = p;
    bus.br_req_i  = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      cyc();
      acked = bus.br_ack_o;
    end
    chk("rstack_seen", acked, 1);
    rst = 1'b1;
    cyc();
    chk("rstack_ack", bus.br_ack_o, 0);
    chk("rstack_level", level, 0);
    chk("rstack_rx", bus.br_svc_rx_o, 0);
    rst = 1'b0;
    exp_q.push_back(p);
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      cyc();
      acked = bus.br_ack_o;
    end
    chk("rstack_reaccept", acked, 1);
    cyc();
    bus.br_req_i = 1'b0;
    cyc();
    chk("rstack_level_after", level, 1);
    pop();
    chk("rstack_drained", level, 0);

    repeat (2) cyc();
    chk("scoreboard_empty", 72'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
